// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter driving the select of a 16:1 mux.
// A grant is held until the owner pulses done or drops its request. The owner
// is then masked out and priority rotates to the requester after the last winner.
// Optional macro MUX_ARB_TIMEOUT_EN adds a hold counter that forces a release
// after MAX_HOLD cycles and pulses timeout.
module mux16_rr_arbiter #(
  parameter int unsigned N_REQ = 16,
  parameter int unsigned SEL_W = 4
`ifdef MUX_ARB_TIMEOUT_EN
  , parameter int unsigned MAX_HOLD = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n;
  logic [N_REQ-1:0] gnt_n;
  logic             gnt_valid_n, timeout_n;

  logic [N_REQ-1:0] cand_c;
  logic [SEL_W-1:0] win_c;
  logic             win_found_c;
  logic             forced_c;
  logic             release_c;
  logic             arb_c;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = 8;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
`endif

  // Requests eligible to win: the current owner is excluded while it holds a grant
  always_comb begin
    cand_c = req;
    if (state == GRANT) cand_c[sel] = 1'b0;
  end

  // Round-robin search starting at ptr; the 4-bit index wraps modulo 16
  always_comb begin
    win_c       = '0;
    win_found_c = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found_c && cand_c[ptr + SEL_W'(i)]) begin
        win_c       = ptr + SEL_W'(i);
        win_found_c = 1'b1;
      end
    end
  end

  // Release of the current grant: done, owner dropped req, or hold limit reached
  always_comb begin
    forced_c = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    forced_c = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`endif
    release_c = done | ~req[sel] | forced_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    sel_n       = sel;
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    timeout_n   = 1'b0;
    arb_c       = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_cnt_n  = hold_cnt;
`endif
    case (state)
      IDLE: arb_c = 1'b1;
      GRANT: begin
        if (release_c) begin
          arb_c     = 1'b1;
          // a release that done or a dropped request also explains is not a timeout
          timeout_n = forced_c & ~done & req[sel];
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (hold_cnt != {HOLD_W{1'b1}}) hold_cnt_n = hold_cnt + HOLD_W'(1);
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    if (arb_c) begin
      if (win_found_c) begin
        state_n     = GRANT;
        sel_n       = win_c;
        gnt_n       = N_REQ'(1) << win_c;
        gnt_valid_n = 1'b1;
        ptr_n       = win_c + SEL_W'(1);
`ifdef MUX_ARB_TIMEOUT_EN
        hold_cnt_n  = '0;
`endif
      end else begin
        state_n     = IDLE;
        gnt_n       = '0;
        gnt_valid_n = 1'b0;
      end
    end
  end

  // State and registered outputs; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt  <= hold_cnt_n;
`endif
    end
  end

endmodule
